// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: default width, ALU_control codes
// and the sequencer state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // ALU_control = {Ainvert, Binvert, operation[1:0]}
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select,
// and the full-adder carry out (always computed, whatever the operation).
module alu_1bit (
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       Ainvert,
    input  logic       Binvert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       sum,
    output logic       carry
);

    logic ai;
    logic bi;

    assign ai = a ^ Ainvert;
    assign bi = b ^ Binvert;

    always_comb begin
        carry = (ai & bi) | (ai & cin) | (bi & cin);
        case (operation)
            2'b00:   sum = ai & bi;
            2'b01:   sum = ai | bi;
            2'b10:   sum = ai ^ bi ^ cin;
            default: sum = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_32bit.sv
// Bit-serial ALU sequencer driving alu_1bit slices LSB first with a registered
// carry. Define ALU_SERIAL_2BIT_EN to process two bits per clock (WIDTH even).
module alu_serial_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

`ifdef ALU_SERIAL_2BIT_EN
    localparam int BPC = 2;
`else
    localparam int BPC = 1;
`endif
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / BPC - 1);

    state_t           state;
    state_t           state_nx;
    logic             load;
    logic             step;
    logic             last;
    logic [CW-1:0]    cnt;
    logic             carry_r;
    logic [3:0]       ctrl_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;

    logic             is_slt;
    logic             arith;
    logic [1:0]       slice_op;
    logic [BPC:0]     chain;
    logic [BPC-1:0]   sums;
    logic             msb_ovf;
    logic             slt_set;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign last = (cnt == LAST);

    // SLT runs the slices as a subtract; its set bit is patched in at the end.
    assign is_slt   = (ctrl_r == ALU_SLT);
    assign slice_op = is_slt ? 2'b10 : ctrl_r[1:0];
    assign arith    = (slice_op == 2'b10);

    assign chain[0] = carry_r;

    for (genvar i = 0; i < BPC; i++) begin : g_slice
        alu_1bit u_slice (
            .a         (a_sh[i]),
            .b         (b_sh[i]),
            .less      (1'b0),
            .Ainvert   (ctrl_r[3]),
            .Binvert   (ctrl_r[2]),
            .cin       (chain[i]),
            .operation (slice_op),
            .sum       (sums[i]),
            .carry     (chain[i+1])
        );
    end

    // Only meaningful on the final step, when the top slice holds the MSB.
    assign msb_ovf   = chain[BPC-1] ^ chain[BPC];
    assign slt_set   = sums[BPC-1] ^ msb_ovf;
    assign res_next  = {sums, res_sh[WIDTH-1:BPC]};
    assign final_res = is_slt ? {{(WIDTH-1){1'b0}}, slt_set} : res_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            carry_r  <= 1'b0;
            ctrl_r   <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            carry_r <= ALU_control[2];
            ctrl_r  <= ALU_control;
            a_sh    <= src1;
            b_sh    <= src2;
        end else if (step) begin
            cnt     <= cnt + CW'(1);
            carry_r <= chain[BPC];
            a_sh    <= a_sh >> BPC;
            b_sh    <= b_sh >> BPC;
            res_sh  <= res_next;
            if (last) begin
                result   <= final_res;
                zero     <= (final_res == '0);
                cout     <= arith & chain[BPC];
                overflow <= arith & msb_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_32bit.sv
// Directed, table-driven bench for alu_serial_32bit plus hand-written
// sequences for start-while-busy, back-to-back starts and reset mid-operation.
module tb_alu_serial_32bit;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_SERIAL_2BIT_EN
    localparam int RUN_CYC = W / 2;
`else
    localparam int RUN_CYC = W;
`endif
    localparam int LAT   = RUN_CYC + 1;
    localparam int LIMIT = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    alu_serial_32bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } vec_t;

    vec_t tv[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns just after the edge that samples it.
    task automatic start_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
        ALU_control = ctrl;
        src1        = a;
        src2        = b;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int e0, input int b0, output int edges, output int busy_n);
        edges  = e0;
        busy_n = b0;
        while (!done && edges < LIMIT) begin
            tick();
            edges++;
            if (busy) busy_n++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] res,
                              input logic z, input logic c, input logic v);
        check({tag, ".result"},   result, res);
        check({tag, ".zero"},     32'(zero), 32'(z));
        check({tag, ".cout"},     32'(cout), 32'(c));
        check({tag, ".overflow"}, 32'(overflow), 32'(v));
    endtask

    int edges;
    int busy_n;
    int done_seen;

    initial begin
        tv[0]  = '{"add_ovf",   ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{"sub_zero",  ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        tv[2]  = '{"slt_neg",   ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{"slt_ovf",   ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1};
        tv[4]  = '{"and",       ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{"or",        ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{"nor",       ALU_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{"add_small", ALU_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{"sub_neg",   ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{"slt_false", ALU_SLT, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        tv[10] = '{"add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        tv[11] = '{"sub_ovf",   ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};

        rst         = 1'b1;
        start       = 1'b0;
        src1        = '0;
        src2        = '0;
        ALU_control = '0;
        tick();
        tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_outs("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            start_op(tv[i].ctrl, tv[i].a, tv[i].b);
            wait_done(1, 32'(busy), edges, busy_n);
            check({tv[i].name, ".latency"}, 32'(edges), 32'(LAT));
            check({tv[i].name, ".busy_cycles"}, 32'(busy_n), 32'(RUN_CYC));
            check_outs(tv[i].name, tv[i].res, tv[i].z, tv[i].c, tv[i].v);
            tick();
            check({tv[i].name, ".done_pulse"}, 32'(done), 32'd0);
        end

        // start pulsed during RUN with different operands must be ignored
        start_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        repeat (9) tick();
        ALU_control = ALU_AND;
        src1        = 32'h1234_5678;
        src2        = 32'h0F0F_0F0F;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_done(11, 11, edges, busy_n);
        check("ignore.latency", 32'(edges), 32'(LAT));
        check_outs("ignore", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check_outs("hold", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

        // start held high through RUN into DONE: second op follows with no gap
        ALU_control = ALU_SUB;
        src1        = 32'h0000_0005;
        src2        = 32'h0000_0005;
        start       = 1'b1;
        tick();
        ALU_control = ALU_ADD;
        src1        = 32'h0000_0003;
        src2        = 32'h0000_0004;
        wait_done(1, 32'(busy), edges, busy_n);
        check("b2b1.latency", 32'(edges), 32'(LAT));
        check_outs("b2b1", 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        check("b2b.busy_no_gap", 32'(busy), 32'd1);
        check("b2b.done_low", 32'(done), 32'd0);
        wait_done(1, 32'(busy), edges, busy_n);
        check("b2b2.latency", 32'(edges), 32'(LAT));
        check_outs("b2b2", 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        // reset mid-RUN aborts with no done pulse and clears the outputs
        tick();
        start_op(ALU_SUB, 32'h0000_0005, 32'h0000_0005);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check_outs("abort", 32'h0, 1'b0, 1'b0, 1'b0);
        done_seen = 0;
        for (int k = 0; k < W + 8; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);
        start_op(ALU_ADD, 32'h0000_0003, 32'h0000_0004);
        wait_done(1, 32'(busy), edges, busy_n);
        check("fresh.latency", 32'(edges), 32'(LAT));
        check_outs("fresh", 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_serial_32bit.md
Name: alu_serial_32bit

Overview:
- Bit-serial 32-bit ALU sequencer. It drives one alu_1bit slice one bit per clock, LSB first, and registers the carry between bits.
- It is the consumer/driver end of the alu_1bit slice interface: it supplies a, b, less, Ainvert, Binvert, cin and operation, and collects sum and carry.
- It is an area-minimal alternative to the 32-slice ripple ALU, with a start/busy/done handshake toward the datapath.

Parameters:
- WIDTH, 32, operand/result width; the counter is clog2(WIDTH) bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- src1  in  WIDTH  operand A; captured on an accepted start.
- src2  in  WIDTH  operand B; captured on an accepted start.
- ALU_control  in  4  {Ainvert, Binvert, operation[1:0]}; captured on an accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- cout  out  1  carry out of the MSB (arithmetic ops only).
- overflow  out  1  signed overflow (arithmetic ops only).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, zero=0, cout=0, overflow=0, bit counter=0, carry register=0.
- Reset has priority over every other input. Reset mid-RUN aborts the operation with no done pulse.
- Supported codes (Ainvert, Binvert, op):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 1100 NOR
  - 0111 SLT
  - Any other code is executed literally on the slice; flags are 0 for non-arithmetic ops.
- States:
  - IDLE: start=1 captures the operands and ALU_control, sets the counter to 0, and sets the carry register to Binvert. Next state RUN.
  - RUN: busy=1. Each cycle the slice gets src1[k], src2[k], the captured Ainvert/Binvert, and cin=the carry register.
    - sum is written into the shift register at bit k; carry is written into the carry register.
    - At k=WIDTH-1, go to DONE.
  - DONE: done=1 for exactly one cycle with valid outputs.
    - start=1 here is accepted (back-to-back, same actions as in IDLE) and the next state is RUN; otherwise IDLE.
- SLT handling:
  - In RUN, the slice operation is forced to 2'b10 (subtract), less=0.
  - At the last bit: set = sum[MSB] XOR overflow; result = {WIDTH-1 zeros, set}.
  - For all other ops, less=0 on every bit.
- Flags (latched at the final bit):
  - overflow = carry-in of the MSB XOR carry-out of the MSB, for ADD/SUB/SLT only.
  - cout = carry-out of the MSB for ADD/SUB/SLT, else 0.
  - zero = (final result == 0).
- Latency: start sampled at edge N; RUN covers edges N+1..N+WIDTH; done is high in the cycle after edge N+WIDTH, i.e. WIDTH+1 clocks after start.
- start while busy: ignored; operands are not re-captured. Changes on src1/src2/ALU_control during RUN have no effect.
- result, zero, cout and overflow hold their values after done until the next final bit completes. The intermediate result register is internal; outputs update only at completion.

Optional Feature:
- Macro ALU_SERIAL_2BIT_EN.
- Defined: two cascaded alu_1bit slices process bits 2k and 2k+1 per cycle. RUN lasts WIDTH/2 cycles, done at WIDTH/2+1 clocks. WIDTH must be even. Flags are taken from the upper slice.
- Undefined: a single slice, one bit per cycle, as above.
- Results are identical in both builds.

Decomposition:
- Package alu_pkg:
  - WIDTH default.
  - ALU_control code constants (AND, OR, ADD, SUB, NOR, SLT).
  - State encoding IDLE/RUN/DONE.
- Sub-module: reuse the existing alu_1bit slice (ports a, b, less, Ainvert, Binvert, cin, operation, sum, carry), instantiated once (twice with ALU_SERIAL_2BIT_EN).
- Sequencer FSM, counter and shift register live in alu_serial_32bit.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> done at start+33 clocks; result=0x80000000, overflow=1, cout=0, zero=0; busy high exactly 32 cycles.
- SUB 0x00000005 - 0x00000005 -> result=0, zero=1, cout=1, overflow=0.
- SLT 0xFFFFFFFF (-1) vs 0x00000001 -> result=0x00000001; SLT 0x80000000 vs 0x7FFFFFFF -> result=0x00000001 (the overflow case).
- AND/OR/NOR of 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x000F000F; cout=0, overflow=0.
- start pulsed again at RUN cycle 10 with different operands -> ignored, first result intact; start held high in DONE -> second op accepted with no idle gap.
- rst asserted at RUN cycle 15 -> next cycle busy=0, all outputs 0, no done pulse; a fresh ADD 3+4 afterwards -> result=7.
